// File: rtl/pe_mac_unit.sv
// Per-core multiply-accumulate datapath: fetches one operand pair per controller step,
// accumulates the signed product, and writes the dot product when the controller closes the cell.
module pe_mac_unit #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pe_active,
   input  logic              vec_fin,
   input  logic [ADDR_W-1:0] left_mem_index,
   input  logic [ADDR_W-1:0] right_mem_index,
   input  logic [ADDR_W-1:0] result_mem_index,
   output logic              left_rd_en,
   output logic [ADDR_W-1:0] left_rd_addr,
   input  logic [DATA_W-1:0] left_rd_data,
   output logic              right_rd_en,
   output logic [ADDR_W-1:0] right_rd_addr,
   input  logic [DATA_W-1:0] right_rd_data,
   output logic              step_fin,
   output logic              res_wr_en,
   output logic [ADDR_W-1:0] res_wr_addr,
   output logic [DATA_W-1:0] res_wr_data,
   output logic              busy,
   output logic [31:0]       cells_done
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_WAIT, ST_ACC, ST_SYNC, ST_WRITE
   } state_t;

   state_t                    state_q, state_d;
   logic        [ACC_W-1:0]   acc_q, acc_d;
   logic                      first_q, first_d;
   logic        [ADDR_W-1:0]  res_addr_q, res_addr_d;
   logic signed [DATA_W-1:0]  l_op_q, l_op_d;
   logic signed [DATA_W-1:0]  r_op_q, r_op_d;
   logic                      rd_en_q, rd_en_d;
   logic        [ADDR_W-1:0]  left_addr_q, left_addr_d;
   logic        [ADDR_W-1:0]  right_addr_q, right_addr_d;
   logic                      step_fin_q, step_fin_d;
   logic                      wr_en_q, wr_en_d;
   logic        [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic        [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic                      busy_q, busy_d;
   logic        [31:0]        cells_done_q, cells_done_d;
   logic signed [ACC_W-1:0]   prod;
   logic                      launch;

   // Operands are sign-extended to the accumulator width, so this is the product mod 2^ACC_W.
   assign prod = l_op_q * r_op_q;

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      first_d      = first_q;
      res_addr_d   = res_addr_q;
      l_op_d       = l_op_q;
      r_op_d       = r_op_q;
      rd_en_d      = 1'b0;
      left_addr_d  = left_addr_q;
      right_addr_d = right_addr_q;
      step_fin_d   = 1'b0;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      cells_done_d = cells_done_q;
      launch       = 1'b0;

      case (state_q)
         ST_IDLE:  launch = pe_active;
         ST_FETCH: state_d = ST_WAIT;
         ST_WAIT: begin
            l_op_d     = left_rd_data;
            r_op_d     = right_rd_data;
            step_fin_d = 1'b1;
            state_d    = ST_ACC;
         end
         ST_ACC: begin
            acc_d   = acc_q + prod;
            state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (vec_fin) begin
               state_d   = ST_WRITE;
               wr_en_d   = 1'b1;
               wr_addr_d = res_addr_q;
               wr_data_d = acc_q[DATA_W-1:0];
            end else begin
               state_d = ST_IDLE;
               launch  = pe_active;
            end
         end
         ST_WRITE: begin
            acc_d        = '0;
            first_d      = 1'b1;
            cells_done_d = cells_done_q + 32'd1;
            state_d      = ST_IDLE;
            launch       = pe_active;
         end
         default: state_d = ST_IDLE;
      endcase

      // SYNC and WRITE fall through the idle decision so back-to-back steps take 4 cycles.
      if (launch) begin
         state_d      = ST_FETCH;
         rd_en_d      = 1'b1;
         left_addr_d  = left_mem_index;
         right_addr_d = right_mem_index;
         if (first_d) begin
            res_addr_d = result_mem_index;
            first_d    = 1'b0;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         acc_q        <= '0;
         first_q      <= 1'b1;
         res_addr_q   <= '0;
         l_op_q       <= '0;
         r_op_q       <= '0;
         rd_en_q      <= 1'b0;
         left_addr_q  <= '0;
         right_addr_q <= '0;
         step_fin_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         busy_q       <= 1'b0;
         cells_done_q <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         first_q      <= first_d;
         res_addr_q   <= res_addr_d;
         l_op_q       <= l_op_d;
         r_op_q       <= r_op_d;
         rd_en_q      <= rd_en_d;
         left_addr_q  <= left_addr_d;
         right_addr_q <= right_addr_d;
         step_fin_q   <= step_fin_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         busy_q       <= busy_d;
         cells_done_q <= cells_done_d;
      end
   end

   assign left_rd_en    = rd_en_q;
   assign right_rd_en   = rd_en_q;
   assign left_rd_addr  = left_addr_q;
   assign right_rd_addr = right_addr_q;
   assign step_fin      = step_fin_q;
   assign res_wr_en     = wr_en_q;
   assign res_wr_addr   = wr_addr_q;
   assign res_wr_data   = wr_data_q;
   assign busy          = busy_q;
   assign cells_done    = cells_done_q;

endmodule

// File: tb/tb_pe_mac_unit.sv
// Directed bench for pe_mac_unit: a driver plays the controller, a dot-product model
// predicts reads and writes, and a negedge monitor checks the DUT every cycle.
module tb_pe_mac_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pe_active = 1'b0;
   logic        vec_fin = 1'b0;
   logic [31:0] left_mem_index = '0;
   logic [31:0] right_mem_index = '0;
   logic [31:0] result_mem_index = '0;
   logic        left_rd_en, right_rd_en, step_fin, res_wr_en, busy;
   logic [31:0] left_rd_addr, right_rd_addr, res_wr_addr, res_wr_data, cells_done;
   logic [31:0] left_rd_data = '0;
   logic [31:0] right_rd_data = '0;

   pe_mac_unit #(.DATA_W(32), .ACC_W(32), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .pe_active(pe_active), .vec_fin(vec_fin),
      .left_mem_index(left_mem_index), .right_mem_index(right_mem_index),
      .result_mem_index(result_mem_index),
      .left_rd_en(left_rd_en), .left_rd_addr(left_rd_addr), .left_rd_data(left_rd_data),
      .right_rd_en(right_rd_en), .right_rd_addr(right_rd_addr), .right_rd_data(right_rd_data),
      .step_fin(step_fin), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
      .res_wr_data(res_wr_data), .busy(busy), .cells_done(cells_done)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          mem_l [64];
   int          mem_r [64];
   int          cell_l [8];
   int          cell_r [8];
   logic [63:0] exp_rd_q [$];
   logic [63:0] exp_wr_q [$];
   logic [31:0] model_acc = '0;
   int          model_cells = 0;
   logic [31:0] last_cell_sum = '0;
   logic [31:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;
   int          last_sf = 0;
   int          gap_exp = 0;
   bit          glitch = 1'b0;
   bit          arm_lat = 1'b0;
   bit          prev_sf = 1'b0;
   int          first_rd_cyc = -1;
   int          first_sf_cyc = -1;
   int          rel_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Operand BRAMs: registered read, output held between strobes.
   always @(posedge clk) begin
      if (left_rd_en)  left_rd_data  <= mem_l[left_rd_addr[5:0]];
      if (right_rd_en) right_rd_data <= mem_r[right_rd_addr[5:0]];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_outputs_zero", 32'(|{left_rd_en, right_rd_en, step_fin, res_wr_en, busy,
             left_rd_addr, right_rd_addr, res_wr_addr, res_wr_data, cells_done}), 32'd0);
         prev_sf = 1'b0;
      end else begin
         if (left_rd_en || right_rd_en) begin
            if (arm_lat && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (exp_rd_q.size() == 0) begin
               chk("unexpected_rd", 32'd1, 32'd0);
            end else begin
               logic [63:0] e;
               e = exp_rd_q.pop_front();
               chk("rd_en_pair", {30'd0, right_rd_en, left_rd_en}, 32'd3);
               chk("left_rd_addr", left_rd_addr, e[63:32]);
               chk("right_rd_addr", right_rd_addr, e[31:0]);
            end
         end
         if (step_fin) begin
            if (arm_lat && first_sf_cyc < 0) first_sf_cyc = cyc;
            chk("step_fin_one_cycle", 32'(prev_sf), 32'd0);
         end
         prev_sf = step_fin;
         if (left_rd_en || step_fin || res_wr_en) chk("busy_when_active", 32'(busy), 32'd1);
         chk("cells_done", cells_done, 32'(model_cells));
         if (res_wr_en) begin
            $display("wr addr=%h data=%h cycle=%0d", res_wr_addr, res_wr_data, cyc);
            if (exp_wr_q.size() == 0) begin
               chk("unexpected_wr", 32'd1, 32'd0);
            end else begin
               logic [63:0] w;
               w = exp_wr_q.pop_front();
               chk("wr_addr", res_wr_addr, w[63:32]);
               chk("wr_data", res_wr_data, w[31:0]);
            end
            last_wr_addr = res_wr_addr;
            last_wr_data = res_wr_data;
            model_cells++;
         end
      end
   end

   // which=1 waits for a read strobe, which=0 for step_fin; bounded either way.
   task automatic wait_for(input bit which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (which ? left_rd_en : step_fin) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_%s: got timeout expected event (cycle %0d)",
                  which ? "rd_en" : "step_fin", cyc);
      end
   endtask

   // Plays the controller for one output cell; indices change in the SYNC cycle.
   task automatic run_cell(input int n, input logic [31:0] res, input bit keep, input int drop_k);
      bit ok;
      for (int k = 0; k < n; k++) begin
         left_mem_index  = 32'(cell_l[k]);
         right_mem_index = 32'(cell_r[k]);
         if (k == 0) result_mem_index = res;
         exp_rd_q.push_back({32'(cell_l[k]), 32'(cell_r[k])});
         model_acc = model_acc + 32'(mem_l[cell_l[k]] * mem_r[cell_r[k]]);
         pe_active = 1'b1;
         if (k == drop_k) begin
            wait_for(1'b1, ok);
            if (!ok) return;
            @(posedge clk); #1;
            pe_active = 1'b0;
         end
         wait_for(1'b0, ok);
         if (!ok) return;
         if (gap_exp != 0) chk("step_gap", 32'(cyc - last_sf), 32'(gap_exp));
         last_sf = cyc;
         gap_exp = 4;
         if (glitch && k < n - 1) vec_fin = 1'b1;
         @(posedge clk); #1;
         vec_fin = 1'b0;
         if (k == n - 1) begin
            vec_fin = 1'b1;
            result_mem_index = res + 32'h40;
            exp_wr_q.push_back({res, model_acc});
            last_cell_sum = model_acc;
            model_acc = '0;
            if (!keep) pe_active = 1'b0;
            @(posedge clk); #1;
            vec_fin = 1'b0;
            gap_exp = keep ? 5 : 0;
         end
         if (k == drop_k) begin
            @(posedge clk); #1;
            chk("idle_after_drop_busy", 32'(busy), 32'd0);
            result_mem_index = res + 32'h80;
            repeat (2) @(posedge clk);
            #1;
            gap_exp = 0;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_rd_q.delete();
      exp_wr_q.delete();
      model_acc = '0;
      model_cells = 0;
      gap_exp = 0;
      pe_active = 1'b0;
      vec_fin = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem_l[i] = 0;
         mem_r[i] = 0;
      end
      mem_l[0] = 1;  mem_l[1] = 2;  mem_l[2] = 3;
      mem_r[0] = 4;  mem_r[1] = 5;  mem_r[2] = 6;
      mem_l[8] = -3; mem_r[8] = 7;
      mem_l[9] = 32'h7FFF_FFFF; mem_r[9] = 2;
      mem_l[10] = 100; mem_r[10] = -5;
      mem_l[11] = 7;   mem_r[11] = 9;
      mem_l[12] = 2;   mem_r[12] = 3;
      mem_l[13] = 4;   mem_r[13] = 5;
      mem_l[14] = -1;  mem_r[14] = -1;
      mem_l[15] = 11;  mem_r[15] = 11;

      // Reset held with pe_active high: monitor checks every output stays zero.
      rst_n = 1'b0;
      pe_active = 1'b1;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      rel_cyc = cyc;
      arm_lat = 1'b1;

      // 3-step vector, with vec_fin glitches outside SYNC on the first two steps.
      glitch = 1'b1;
      cell_l[0] = 0; cell_l[1] = 1; cell_l[2] = 2;
      cell_r[0] = 0; cell_r[1] = 1; cell_r[2] = 2;
      run_cell(3, 32'h10, 1'b1, -1);
      glitch = 1'b0;
      arm_lat = 1'b0;
      @(negedge clk); #1;
      chk("t2_model_sum", last_cell_sum, 32'd32);
      chk("t2_wr_addr", last_wr_addr, 32'h10);
      chk("t2_wr_data", last_wr_data, 32'd32);
      chk("lat_first_fetch", 32'(first_rd_cyc), 32'(rel_cyc + 1));
      chk("lat_first_step_fin", 32'(first_sf_cyc), 32'(rel_cyc + 3));

      // Signed product, then a product whose sum wraps.
      cell_l[0] = 8; cell_r[0] = 8;
      run_cell(1, 32'h20, 1'b1, -1);
      @(negedge clk); #1;
      chk("t3_model_neg", last_cell_sum, 32'hFFFF_FFEB);
      chk("t3_wr_neg", last_wr_data, 32'hFFFF_FFEB);
      cell_l[0] = 8; cell_l[1] = 9;
      cell_r[0] = 8; cell_r[1] = 9;
      run_cell(2, 32'h21, 1'b1, -1);
      @(negedge clk); #1;
      chk("t3_model_wrap", last_cell_sum, 32'hFFFF_FFE9);
      chk("t3_wr_wrap", last_wr_data, 32'hFFFF_FFE9);

      // pe_active dropped during WAIT of the first step, then resumed.
      cell_l[0] = 10; cell_l[1] = 11;
      cell_r[0] = 10; cell_r[1] = 11;
      run_cell(2, 32'h30, 1'b0, 0);
      @(negedge clk); #1;
      chk("t4_model_sum", last_cell_sum, 32'hFFFF_FE4B);
      chk("t4_wr_addr", last_wr_addr, 32'h30);
      chk("t4_wr_data", last_wr_data, 32'hFFFF_FE4B);

      // Two consecutive cells after a fresh reset.
      do_reset();
      cell_l[0] = 12; cell_l[1] = 13;
      cell_r[0] = 12; cell_r[1] = 13;
      run_cell(2, 32'd5, 1'b1, -1);
      @(negedge clk); #1;
      chk("t5_wr_addr_5", last_wr_addr, 32'd5);
      chk("t5_wr_data_5", last_wr_data, 32'd26);
      cell_l[0] = 14; cell_r[0] = 14;
      run_cell(1, 32'd6, 1'b0, -1);
      repeat (2) @(negedge clk);
      chk("t5_wr_addr_6", last_wr_addr, 32'd6);
      chk("t5_wr_data_6", last_wr_data, 32'd1);
      chk("t5_cells_done", cells_done, 32'd2);

      // Reset asserted while the write strobe is up.
      cell_l[0] = 15; cell_r[0] = 15;
      run_cell(1, 32'h40, 1'b0, -1);
      chk("t6_in_write", 32'(res_wr_en), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_wr_dropped", 32'(res_wr_en), 32'd0);
      chk("t6_busy_cleared", 32'(busy), 32'd0);
      chk("t6_cells_done", cells_done, 32'd0);
      do_reset();
      run_cell(1, 32'h41, 1'b0, -1);
      repeat (2) @(negedge clk);
      chk("t6_acc_cleared", last_wr_data, 32'd121);
      chk("t6_wr_addr", last_wr_addr, 32'h41);
      chk("t6_cells_after", cells_done, 32'd1);

      repeat (3) @(negedge clk);
      chk("leftover_reads", 32'(exp_rd_q.size()), 32'd0);
      chk("leftover_writes", 32'(exp_wr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
